// File: rtl/mfp_sram_arbiter.sv
// rtl/mfp_sram_arbiter.sv - async SRAM sequencer shared by the CPU slave and VGA fetch
// VGA wins ties; a starvation counter forces a CPU grant after STARVE_LIMIT VGA wins.
module mfp_sram_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 48,
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                HCLK,
  input  logic                SI_Reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W/8-1:0] cpu_be,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ack,
  input  logic                vga_req,
  input  logic [ADDR_W-1:0]   vga_addr,
  output logic [DATA_W-1:0]   vga_rdata,
  output logic                vga_ack,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W/16-1:0] sram_ce_n,
  output logic [DATA_W/16-1:0] sram_oe_n,
  output logic [DATA_W/16-1:0] sram_we_n,
  output logic [DATA_W/16-1:0] sram_ub_n,
  output logic [DATA_W/16-1:0] sram_lb_n,
  output logic [DATA_W-1:0]   sram_dout,
  output logic                sram_dout_en,
  input  logic [DATA_W-1:0]   sram_din,
  output logic                busy
);

  localparam int NCHIP = DATA_W / 16;
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [SC_W-1:0]  STARVE_MAX  = SC_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_COMPLETE
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_we;
  logic [BE_W-1:0]     lat_be;
  logic [DATA_W-1:0]   lat_wdata;
  logic                lat_vga;
  logic [CNT_W-1:0]    strobe_cnt;
  logic [SC_W-1:0]     starve_cnt;
  logic                grant_cpu;
  logic                grant_vga;
  logic                strobe_done;

  // Only meaningful in IDLE; both are ignored in every other state.
  assign grant_cpu   = cpu_req && (!vga_req || (starve_cnt == STARVE_MAX));
  assign grant_vga   = vga_req && !grant_cpu;
  assign strobe_done = (strobe_cnt == STROBE_LAST);

  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (cpu_req || vga_req) state_d = S_SETUP;
      S_SETUP:    state_d = S_STROBE;
      S_STROBE:   if (strobe_done) state_d = S_COMPLETE;
      S_COMPLETE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_wdata  <= '0;
      lat_vga    <= 1'b0;
      strobe_cnt <= '0;
      starve_cnt <= '0;
      cpu_rdata  <= '0;
      vga_rdata  <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        if (grant_cpu) begin
          lat_addr   <= cpu_addr;
          lat_we     <= cpu_we;
          lat_be     <= cpu_be;
          lat_wdata  <= cpu_wdata;
          lat_vga    <= 1'b0;
          starve_cnt <= '0;
        end else if (grant_vga) begin
          lat_addr <= vga_addr;
          lat_we   <= 1'b0;
          lat_be   <= '1;
          lat_vga  <= 1'b1;
          if (cpu_req && (starve_cnt != STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
        end
      end

      if (state_q == S_STROBE) begin
        strobe_cnt <= strobe_cnt + 1'b1;
      end else begin
        strobe_cnt <= '0;
      end

      // Read data is sampled at the end of the full strobe so the SRAM access time is met.
      if ((state_q == S_STROBE) && strobe_done && !lat_we) begin
        if (lat_vga) vga_rdata <= sram_din;
        else         cpu_rdata <= sram_din;
      end
    end
  end

  always_comb begin
    sram_ce_n    = '1;
    sram_oe_n    = '1;
    sram_we_n    = '1;
    sram_ub_n    = '1;
    sram_lb_n    = '1;
    sram_dout_en = 1'b0;
    cpu_ack      = 1'b0;
    vga_ack      = 1'b0;
    if (state_q != S_IDLE) begin
      sram_ce_n    = '0;
      sram_dout_en = lat_we;
      for (int i = 0; i < NCHIP; i++) begin
        sram_lb_n[i] = ~lat_be[2*i];
        sram_ub_n[i] = ~lat_be[2*i+1];
      end
    end
    if (((state_q == S_SETUP) || (state_q == S_STROBE)) && !lat_we) sram_oe_n = '0;
    if ((state_q == S_STROBE) && lat_we) sram_we_n = '0;
    // COMPLETE keeps address, chip enables and data driven for write hold time.
    if (state_q == S_COMPLETE) begin
      cpu_ack = !lat_vga;
      vga_ack = lat_vga;
    end
  end

  assign sram_addr = lat_addr;
  assign sram_dout = lat_wdata;
  assign busy      = (state_q != S_IDLE);

endmodule
